bsg_adder_cin_multiword: RTL and testbench
==========================================

BSG_ADDER_CIN_MULTIWORD -- requirements
Module: bsg_adder_cin_multiword

Interface
REQ-001 The block SHALL have parameter width_p, default 64, meaning limb width in bits.
REQ-002 The block SHALL have parameter max_limbs_p, default 8, meaning the maximum number of limbs per operand.
REQ-003 Port clk_i SHALL be an input, 1 bit: the single clock.
REQ-004 Port reset_n_i SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port v_i SHALL be an input, 1 bit: input limb valid.
REQ-006 Port ready_o SHALL be an output, 1 bit: input limb ready.
REQ-007 Port a_i SHALL be an input, width_p bits: operand A limb, least-significant limb first.
REQ-008 Port b_i SHALL be an input, width_p bits: operand B limb.
REQ-009 Port cin_i SHALL be an input, 1 bit: carry-in for the first limb of an operation.
REQ-010 Port last_i SHALL be an input, 1 bit: marks the most-significant limb.
REQ-011 Port v_o SHALL be an output, 1 bit: result limb valid.
REQ-012 Port ready_and_i SHALL be an input, 1 bit: downstream ready.
REQ-013 Port o SHALL be an output, width_p bits: sum limb.
REQ-014 Port cout_o SHALL be an output, 1 bit: carry-out of this limb.
REQ-015 Port last_o SHALL be an output, 1 bit: registered copy of last_i.
REQ-016 Port idx_o SHALL be an output, $clog2(max_limbs_p) bits: limb index within the operation.
REQ-017 Port error_o SHALL be an output, 1 bit: sticky limb-overflow flag.

Function
REQ-018 Input accept SHALL be defined as v_i & ready_o; output handoff SHALL be defined as v_o & ready_and_i.
REQ-019 ready_o SHALL equal ~v_o | ready_and_i, giving a one-deep output register with a same-cycle refill.
REQ-020 The FSM SHALL have two states: IDLE (awaiting the first limb) and BUSY (inside a multi-limb operation).
REQ-021 On an accept in IDLE, the carry used SHALL be cin_i; on an accept in BUSY, it SHALL be carry_r.
REQ-022 The per-accept sum SHALL be the (width_p+1)-bit value a_i + b_i + carry-used; the low width_p bits SHALL go to o and the MSB SHALL go to cout_o and carry_r.
REQ-023 Latency SHALL be exactly 1 cycle: the outputs of an accept SHALL be registered and visible on the next cycle.
REQ-024 Transitions:
- IDLE→BUSY on an accept with last_i=0.
- BUSY→IDLE on an accept with last_i=1.
- An accept with last_i=1 in IDLE SHALL leave the FSM in IDLE (single-limb operation).
REQ-025 On an accept with last_i=1, carry_r SHALL be cleared to 0; the final carry SHALL appear only on cout_o.
REQ-026 idx_o SHALL be 0 for the first limb and SHALL increment per accepted limb within an operation.
REQ-027 When idx reaches max_limbs_p-1 on an accept with last_i=0:
- error_o SHALL set and hold until reset.
- The limb SHALL still be summed.
- The index counter SHALL hold at max_limbs_p-1.
- The FSM SHALL remain in BUSY.
REQ-028 v_o SHALL set on an accept, and SHALL clear on a handoff with no simultaneous accept; a simultaneous handoff and accept SHALL keep v_o=1 with the new data.
REQ-029 o, cout_o, last_o and idx_o SHALL hold stable while v_o=1 and ready_and_i=0.
REQ-030 Inputs SHALL be ignored when v_i=0; cin_i SHALL be ignored in BUSY.

Reset
REQ-031 Asserting reset_n_i low SHALL immediately force:
- state=IDLE
- v_o=0
- o=0
- cout_o=0
- last_o=0
- idx_o=0
- carry_r=0
- error_o=0
REQ-032 A reset mid-operation SHALL abandon the partial operation and discard any pending output limb.
REQ-033 ready_o SHALL be 1 during reset and in the first cycle after deassertion.

Structure
REQ-034 The IDLE/BUSY state enum SHALL reside in the shared bsg_misc package.
REQ-035 The per-limb add SHALL be one instance of the existing sub-module bsg_adder_cin (width_p), driven by the selected carry.
REQ-036 The carry-out SHALL be computed locally as the width_p+1 sum MSB.
REQ-037 All state SHALL be in a single always_ff sensitive to posedge clk_i, negedge reset_n_i.

Verification
REQ-038 Single limb: a_i=64'hFFFF_FFFF_FFFF_FFFF, b_i=0, cin_i=1, last_i=1, ready_and_i=1 -> next cycle v_o=1, o=0, cout_o=1, last_o=1, idx_o=0.
REQ-039 Three-limb carry ripple: limbs A={FFFF..FF, FFFF..FF, 0}, B={1, 0, 0}, cin_i=0 -> o={0, 0, 1}, cout_o={1, 1, 0}, idx_o={0, 1, 2}.
REQ-040 Backpressure: hold ready_and_i=0 for 3 cycles after the first limb -> ready_o=0 and o stable; on release, the second limb is accepted in the same cycle as the handoff.
REQ-041 cin_i ignored in BUSY: limb0 (1 + 1, cin_i=0), limb1 (0 + 0, cin_i=1, last_i=1) -> o1=0, cout_o=0.
REQ-042 Overflow: with max_limbs_p=4, 5 limbs and no last_i -> error_o rises on the 4th accept, idx_o holds 3, error_o remains 1 until reset.
REQ-043 Reset mid-operation: assert reset_n_i low after limb1 of 3 -> v_o=0 immediately; the next limb after release uses cin_i, and idx_o=0.

Source files
------------

// File: rtl/bsg_misc_pkg.sv
// Shared miscellaneous definitions for the bsg arithmetic blocks.
//   add_state_e : operation tracking state of the multi-word adder
//                 (StIdle = awaiting first limb, StBusy = inside an operation).
package bsg_misc_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } add_state_e;

endpackage

// File: rtl/bsg_adder_cin.sv
// Combinational limb adder with carry-in.
//   a_i, b_i : width_p-bit addends
//   cin_i    : carry-in
//   o        : low width_p bits of a_i + b_i + cin_i
module bsg_adder_cin #(
  parameter int unsigned width_p = 64
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               cin_i,
  output logic [width_p-1:0] o
);

  assign o = a_i + b_i + {{(width_p-1){1'b0}}, cin_i};

endmodule

// File: rtl/bsg_adder_cin_multiword.sv
// Multi-limb adder: adds two operands presented one limb per accept,
// least-significant limb first, rippling the carry between limbs.
//   clk_i, reset_n_i      : clock, asynchronous active-low reset
//   v_i/ready_o           : input limb handshake
//   a_i, b_i, cin_i       : operand limbs, carry-in (first limb only)
//   last_i                : marks the most-significant limb
//   v_o/ready_and_i       : output limb handshake (one-deep output register)
//   o, cout_o             : sum limb and its carry-out
//   last_o, idx_o         : registered last flag and limb index
//   error_o               : sticky limb-count overflow
module bsg_adder_cin_multiword
  import bsg_misc_pkg::*;
#(
  parameter int unsigned width_p     = 64,
  parameter int unsigned max_limbs_p = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [width_p-1:0]             a_i,
  input  logic [width_p-1:0]             b_i,
  input  logic                           cin_i,
  input  logic                           last_i,
  output logic                           v_o,
  input  logic                           ready_and_i,
  output logic [width_p-1:0]             o,
  output logic                           cout_o,
  output logic                           last_o,
  output logic [$clog2(max_limbs_p)-1:0] idx_o,
  output logic                           error_o
);

  localparam int unsigned IdxW = $clog2(max_limbs_p);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(max_limbs_p - 1);

  add_state_e        state_q, state_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;         // index of the next limb to accept
  logic              v_q, v_d;
  logic [width_p-1:0] o_q, o_d;
  logic              cout_q, cout_d;
  logic              last_q, last_d;
  logic [IdxW-1:0]   idx_o_q, idx_o_d;
  logic              error_q, error_d;

  logic               accept, handoff;
  logic               carry_sel;
  logic [IdxW-1:0]    idx_cur;
  logic [width_p-1:0] sum_limb;
  logic               sum_cout;

  assign ready_o = ~v_q | ready_and_i;
  assign accept  = v_i & ready_o;
  assign handoff = v_q & ready_and_i;

  // A fresh operation takes cin_i and restarts the index; inside one, the rippled carry.
  assign carry_sel = (state_q == StBusy) ? carry_q : cin_i;
  assign idx_cur   = (state_q == StBusy) ? idx_q : '0;

  bsg_adder_cin #(
    .width_p(width_p)
  ) u_adder (
    .a_i  (a_i),
    .b_i  (b_i),
    .cin_i(carry_sel),
    .o    (sum_limb)
  );

  // Carry-out is the MSB of the (width_p+1)-bit sum.
  assign sum_cout = 1'(({1'b0, a_i} + {1'b0, b_i} + {{width_p{1'b0}}, carry_sel}) >> width_p);

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    v_d     = v_q;
    o_d     = o_q;
    cout_d  = cout_q;
    last_d  = last_q;
    idx_o_d = idx_o_q;
    error_d = error_q;

    if (accept) begin
      v_d     = 1'b1;
      o_d     = sum_limb;
      cout_d  = sum_cout;
      last_d  = last_i;
      idx_o_d = idx_cur;
      if (last_i) begin
        state_d = StIdle;
        carry_d = 1'b0;
        idx_d   = '0;
      end else begin
        state_d = StBusy;
        carry_d = sum_cout;
        if (idx_cur == IdxMax) begin
          // Too many limbs: flag it, keep summing, pin the index.
          error_d = 1'b1;
          idx_d   = IdxMax;
        end else begin
          idx_d = idx_cur + 1'b1;
        end
      end
    end else if (handoff) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      carry_q <= 1'b0;
      idx_q   <= '0;
      v_q     <= 1'b0;
      o_q     <= '0;
      cout_q  <= 1'b0;
      last_q  <= 1'b0;
      idx_o_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      v_q     <= v_d;
      o_q     <= o_d;
      cout_q  <= cout_d;
      last_q  <= last_d;
      idx_o_q <= idx_o_d;
      error_q <= error_d;
    end
  end

  assign v_o     = v_q;
  assign o       = o_q;
  assign cout_o  = cout_q;
  assign last_o  = last_q;
  assign idx_o   = idx_o_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_bsg_adder_cin_multiword.sv
// Directed bench for bsg_adder_cin_multiword (width 64, max 4 limbs).
module tb_bsg_adder_cin_multiword;

  localparam int unsigned W = 64;
  localparam int unsigned M = 4;
  localparam logic [W-1:0] Ones = {W{1'b1}};

  logic          clk = 1'b0;
  logic          reset_n;
  logic          v_i, ready_o, cin_i, last_i, v_o, ready_and_i, cout_o, last_o, error_o;
  logic [W-1:0]  a_i, b_i, o;
  logic [1:0]    idx_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_adder_cin_multiword #(
    .width_p    (W),
    .max_limbs_p(M)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .cin_i      (cin_i),
    .last_i     (last_i),
    .v_o        (v_o),
    .ready_and_i(ready_and_i),
    .o          (o),
    .cout_o     (cout_o),
    .last_o     (last_o),
    .idx_o      (idx_o),
    .error_o    (error_o)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one limb for a single cycle; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic last);
    a_i    = a;
    b_i    = b;
    cin_i  = cin;
    last_i = last;
    v_i    = 1'b1;
    @(posedge clk);
    #1;
    v_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_limb(input string tag, input logic [W-1:0] exp_o, input logic exp_c,
                            input logic exp_last, input logic [1:0] exp_idx);
    check({tag, ".v"}, W'(v_o), W'(1'b1));
    check({tag, ".o"}, o, exp_o);
    check({tag, ".cout"}, W'(cout_o), W'(exp_c));
    check({tag, ".last"}, W'(last_o), W'(exp_last));
    check({tag, ".idx"}, W'(idx_o), W'(exp_idx));
  endtask

  initial begin
    reset_n     = 1'b0;
    v_i         = 1'b0;
    a_i         = '0;
    b_i         = '0;
    cin_i       = 1'b0;
    last_i      = 1'b0;
    ready_and_i = 1'b1;

    // Reset values
    #3;
    check("rst.v", W'(v_o), '0);
    check("rst.o", o, '0);
    check("rst.cout", W'(cout_o), '0);
    check("rst.last", W'(last_o), '0);
    check("rst.idx", W'(idx_o), '0);
    check("rst.err", W'(error_o), '0);
    check("rst.ready", W'(ready_o), W'(1'b1));
    step();
    reset_n = 1'b1;
    check("post_rst.ready", W'(ready_o), W'(1'b1));

    // Single limb with carry-in
    send(Ones, '0, 1'b1, 1'b1);
    check_limb("single", '0, 1'b1, 1'b1, 2'd0);
    step();
    check("single.drain", W'(v_o), '0);

    // Three-limb carry ripple
    send(Ones, 64'd1, 1'b0, 1'b0);
    check_limb("rip0", '0, 1'b1, 1'b0, 2'd0);
    send(Ones, '0, 1'b0, 1'b0);
    check_limb("rip1", '0, 1'b1, 1'b0, 2'd1);
    send('0, '0, 1'b0, 1'b1);
    check_limb("rip2", 64'd1, 1'b0, 1'b1, 2'd2);

    // cin_i ignored while busy
    send(64'd1, 64'd1, 1'b0, 1'b0);
    check_limb("cinb0", 64'd2, 1'b0, 1'b0, 2'd0);
    send('0, '0, 1'b1, 1'b1);
    check_limb("cinb1", '0, 1'b0, 1'b1, 2'd1);
    step();

    // Backpressure: limb1 waits behind a stalled output
    send(64'd5, 64'd6, 1'b0, 1'b0);
    check_limb("bp0", 64'd11, 1'b0, 1'b0, 2'd0);
    ready_and_i = 1'b0;
    a_i    = 64'd7;
    b_i    = 64'd8;
    cin_i  = 1'b0;
    last_i = 1'b1;
    v_i    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp.ready", W'(ready_o), '0);
      check("bp.hold_o", o, 64'd11);
      check("bp.hold_idx", W'(idx_o), '0);
    end
    ready_and_i = 1'b1;
    #1;
    check("bp.refill_ready", W'(ready_o), W'(1'b1));
    step();
    v_i = 1'b0;
    check_limb("bp1", 64'd15, 1'b0, 1'b1, 2'd1);
    step();
    check("bp.drain", W'(v_o), '0);

    // Overflow with 5 limbs and no last
    for (int i = 0; i < 5; i++) begin
      send(64'd1, 64'd1, 1'b0, 1'b0);
      check("ovf.o", o, 64'd2);
      check("ovf.idx", W'(idx_o), W'((i < 3) ? i : 3));
      check("ovf.err", W'(error_o), W'(i >= 3));
    end
    step();
    step();
    check("ovf.sticky", W'(error_o), W'(1'b1));

    // Reset clears the sticky error
    reset_n = 1'b0;
    #1;
    check("ovf_rst.err", W'(error_o), '0);
    step();
    reset_n = 1'b1;

    // Reset mid-operation: partial carry and pending limb are dropped
    send(Ones, 64'd1, 1'b0, 1'b0);
    check_limb("mid0", '0, 1'b1, 1'b0, 2'd0);
    send(Ones, '0, 1'b0, 1'b0);
    check_limb("mid1", '0, 1'b1, 1'b0, 2'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst.v", W'(v_o), '0);
    check("mid_rst.idx", W'(idx_o), '0);
    check("mid_rst.ready", W'(ready_o), W'(1'b1));
    step();
    reset_n = 1'b1;
    check("mid_rel.ready", W'(ready_o), W'(1'b1));
    send('0, '0, 1'b0, 1'b1);
    check_limb("mid_new0", '0, 1'b0, 1'b1, 2'd0);
    send(64'd5, 64'd5, 1'b1, 1'b1);
    check_limb("mid_new1", 64'd11, 1'b0, 1'b1, 2'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
